// File: rtl/can_crc_ctrl_if.sv
// rtl/can_crc_ctrl_if.sv - bit-stream and status signals of the CAN CRC controller
interface can_crc_ctrl_if;
  logic        bit_en;
  logic        bitin;
  logic        stuff;
  logic        sof;
  logic        crc_start;
  logic        tx_mode;
  logic        abort;
  logic [14:0] crc_reg;
  logic        crc_out;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;

  modport master (
    output bit_en, bitin, stuff, sof, crc_start, tx_mode, abort,
    input  crc_reg, crc_out, busy, done, crc_ok, crc_err
  );

  modport slave (
    input  bit_en, bitin, stuff, sof, crc_start, tx_mode, abort,
    output crc_reg, crc_out, busy, done, crc_ok, crc_err
  );
endinterface

// File: rtl/can_crc_ctrl.sv
// rtl/can_crc_ctrl.sv - CAN CRC-15 generator/checker with transmit and receive CRC field sequencing
module can_crc_ctrl (
  input logic          clock,
  input logic          reset,
  can_crc_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_TXCRC = 3'd2;
  localparam logic [2:0] S_RXCRC = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [14:0] CAN_POLY = 15'h4599;

  logic [2:0]  state_q, state_d;
  logic [14:0] crc_q, crc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        bit_upd;
  logic [14:0] crc_step;

  function automatic logic [14:0] crc_next(input logic [14:0] c, input logic b);
    logic nxt;
    nxt = b ^ c[14];
    return {c[13:0], 1'b0} ^ (nxt ? CAN_POLY : 15'h0000);
  endfunction

  assign bit_upd  = bus.bit_en & ~bus.stuff;
  assign crc_step = crc_next(crc_q, bus.bitin);

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    err_d   = err_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      ok_d    = 1'b0;
      err_d   = 1'b0;
    end else if (bus.sof && bus.bit_en) begin
      state_d = S_CALC;
      crc_d   = crc_next(15'h0000, bus.bitin);
      ok_d    = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_CALC: begin
          if (bit_upd) crc_d = crc_step;
          // The bit of this clock is folded in before the CRC field starts.
          if (bus.crc_start) begin
            cnt_d   = 4'd15;
            state_d = bus.tx_mode ? S_TXCRC : S_RXCRC;
          end
        end
        S_TXCRC: begin
          if (bit_upd) begin
            crc_d = {crc_q[13:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_DONE;
          end
        end
        S_RXCRC: begin
          if (bit_upd) begin
            crc_d = crc_step;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = S_DONE;
              ok_d    = (crc_step == 15'h0000);
              err_d   = (crc_step != 15'h0000);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      crc_q   <= 15'h0000;
      cnt_q   <= 4'd0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign bus.crc_reg = crc_q;
  assign bus.crc_out = (state_q == S_TXCRC) ? crc_q[14] : 1'b0;
  assign bus.busy    = (state_q == S_CALC) || (state_q == S_TXCRC) || (state_q == S_RXCRC);
  assign bus.done    = (state_q == S_DONE);
  assign bus.crc_ok  = ok_q;
  assign bus.crc_err = err_q;
endmodule

// File: tb/tb_can_crc_ctrl.sv
// tb/tb_can_crc_ctrl.sv - randomized and directed checks of can_crc_ctrl against a queue-based CRC model
module tb_can_crc_ctrl;
  logic clock;
  logic rst_n;
  can_crc_ctrl_if bus ();

  can_crc_ctrl dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a list of data bits plus a list of CRC-field bits.
  function automatic logic [14:0] crc_of(input bit q[$], input logic [14:0] init);
    logic [14:0] c;
    c = init;
    foreach (q[i]) begin
      if (q[i] ^ c[14]) c = {c[13:0], 1'b0} ^ 15'h4599;
      else              c = {c[13:0], 1'b0};
    end
    return c;
  endfunction

  int          phase = 0;  // 0 idle, 1 data, 2 sending CRC, 3 receiving CRC, 4 done
  int          mode  = 0;  // which frame kind the CRC register currently reflects
  int          k     = 0;
  bit          data_q[$];
  bit          rx_q[$];
  logic [14:0] exp_crc = 15'h0;
  logic        exp_ok = 1'b0, exp_err = 1'b0;
  bit          started = 0;

  always @(posedge clock) begin
    bit touched;
    logic [14:0] base;
    touched = 0;
    started = 1;
    if (!rst_n) begin
      phase = 0; mode = 0; k = 0; data_q = {}; rx_q = {};
      exp_crc = 15'h0; exp_ok = 0; exp_err = 0;
    end else if (bus.abort) begin
      phase = 0; exp_ok = 0; exp_err = 0;
    end else if (bus.sof && bus.bit_en) begin
      data_q = {}; rx_q = {}; data_q.push_back(bus.bitin);
      k = 0; phase = 1; mode = 1; exp_ok = 0; exp_err = 0; touched = 1;
    end else begin
      case (phase)
        1: begin
          if (bus.bit_en && !bus.stuff) data_q.push_back(bus.bitin);
          if (bus.crc_start) begin
            k = 0; phase = bus.tx_mode ? 2 : 3; mode = phase;
          end
          touched = 1;
        end
        2: if (bus.bit_en && !bus.stuff) begin
          k++; touched = 1;
          if (k == 15) phase = 4;
        end
        3: if (bus.bit_en && !bus.stuff) begin
          rx_q.push_back(bus.bitin); k++; touched = 1;
          if (k == 15) begin
            phase = 4;
            exp_ok  = (crc_of(rx_q, crc_of(data_q, 15'h0)) == 15'h0);
            exp_err = !exp_ok;
          end
        end
        4: phase = 0;
        default: phase = 0;
      endcase
    end
    if (touched) begin
      base = crc_of(data_q, 15'h0);
      case (mode)
        2:       exp_crc = base << k;
        3:       exp_crc = crc_of(rx_q, base);
        default: exp_crc = base;
      endcase
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("crc_reg", bus.crc_reg, exp_crc);
      chk("crc_out", {14'h0, bus.crc_out}, {14'h0, (phase == 2) ? exp_crc[14] : 1'b0});
      chk("busy",    {14'h0, bus.busy},    {14'h0, (phase >= 1 && phase <= 3)});
      chk("done",    {14'h0, bus.done},    {14'h0, (phase == 4)});
      chk("crc_ok",  {14'h0, bus.crc_ok},  {14'h0, exp_ok});
      chk("crc_err", {14'h0, bus.crc_err}, {14'h0, exp_err});
    end
  end

  task automatic cyc(input logic be, input logic bi, input logic st, input logic sf,
                     input logic cs, input logic tx, input logic ab, input logic rs);
    @(negedge clock); #1;
    bus.bit_en = be; bus.bitin = bi; bus.stuff = st; bus.sof = sf;
    bus.crc_start = cs; bus.tx_mode = tx; bus.abort = ab; rst_n = rs;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic settle;
    @(posedge clock); #1;
  endtask

  // Frame with data bits 0,1 (SOF bit then one data bit), optionally with a stuff bit between them.
  task automatic prefix(input bit with_stuff);
    cyc(1, 0, 0, 1, 0, 0, 0, 1);
    if (with_stuff) cyc(1, 1'($urandom_range(0, 1)), 1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rx_frame(input int flip, input bit with_stuff);
    logic [14:0] ref_crc;
    ref_crc = 15'h4599;
    prefix(with_stuff);
    cyc(0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 14; i >= 0; i--) begin
      if (with_stuff && (i % 4 == 0)) cyc(1, 1'($urandom_range(0, 1)), 1, 0, 0, 0, 0, 1);
      cyc(1, ref_crc[i] ^ (i == flip), 0, 0, 0, 0, 0, 1);
    end
    settle();
  endtask

  logic [14:0] seq;
  bit          bq[$];

  initial begin
    rst_n = 1'b0;
    bus.bit_en = 0; bus.bitin = 0; bus.stuff = 0; bus.sof = 0;
    bus.crc_start = 0; bus.tx_mode = 0; bus.abort = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", {14'h0, bus.busy}, 15'h0);
    chk("reset_crc", bus.crc_reg, 15'h0);
    bq = {1'b0, 1'b1};
    chk("model_pin", crc_of(bq, 15'h0), 15'h4599);
    quiet(2);

    prefix(0);
    settle();
    chk("calc_crc", bus.crc_reg, 15'h4599);
    chk("calc_busy", {14'h0, bus.busy}, 15'h1);

    cyc(0, 0, 0, 0, 1, 1, 0, 1);
    settle();
    for (int i = 14; i >= 0; i--) begin
      seq[i] = bus.crc_out;
      cyc(1, 0, 0, 0, 0, 0, 0, 1);
      settle();
    end
    chk("tx_seq", seq, 15'b100010110011001);
    chk("tx_done", {14'h0, bus.done}, 15'h1);
    chk("tx_flags", {13'h0, bus.crc_ok, bus.crc_err}, 15'h0);
    quiet(2);

    rx_frame(-1, 0);
    chk("rx_done", {14'h0, bus.done}, 15'h1);
    chk("rx_ok", {13'h0, bus.crc_ok, bus.crc_err}, 15'h2);
    chk("rx_crc", bus.crc_reg, 15'h0);
    quiet(2);
    chk("rx_ok_held", {13'h0, bus.crc_ok, bus.crc_err}, 15'h2);

    rx_frame(3, 0);
    chk("rx_err", {13'h0, bus.crc_ok, bus.crc_err}, 15'h1);
    quiet(2);

    rx_frame(-1, 1);
    chk("stuff_ok", {13'h0, bus.crc_ok, bus.crc_err}, 15'h2);
    chk("stuff_crc", bus.crc_reg, 15'h0);
    quiet(2);

    prefix(0);
    cyc(0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(1, 1'(i & 1), 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 1, 1);
    settle();
    chk("abort_state", {12'h0, bus.busy, bus.done, bus.crc_ok, bus.crc_err}, 15'h0);
    cyc(1, 0, 0, 1, 0, 0, 1, 1);
    settle();
    chk("abort_sof", {14'h0, bus.busy}, 15'h0);
    quiet(2);

    prefix(0);
    cyc(0, 0, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 1, 1, 1, 1, 0);
    settle();
    chk("rst_crc", bus.crc_reg, 15'h0);
    chk("rst_outs", {11'h0, bus.crc_out, bus.busy, bus.done, bus.crc_ok, bus.crc_err}, 15'h0);
    quiet(1);
    rx_frame(-1, 0);
    chk("post_rst_ok", {13'h0, bus.crc_ok, bus.crc_err}, 15'h2);
    quiet(2);

    for (int n = 0; n < 4000; n++) begin
      logic be, sf, cs, ab, rs;
      be = ($urandom_range(0, 99) < 65);
      sf = be && ($urandom_range(0, 99) < 3);
      cs = ($urandom_range(0, 99) < 5);
      ab = ($urandom_range(0, 199) < 2);
      rs = ($urandom_range(0, 399) != 0);
      cyc(be, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 12), sf, cs,
          1'($urandom_range(0, 1)), ab, rs);
    end
    quiet(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
